// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and sizing for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned REG_SEL_W  = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STAMP_W    = 3;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  // One queued writeback beat.
  typedef struct packed {
    logic [REG_SEL_W-1:0] sel;
    logic [DATA_W-1:0]    data;
    logic [STAMP_W-1:0]   stamp;
  } wb_entry_t;

  // Source that received the most recent grant.
  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } arb_state_t;

  // a is older than b when b is ahead of a by less than half the stamp range.
  function automatic logic is_older(input logic [STAMP_W-1:0] a,
                                    input logic [STAMP_W-1:0] b);
    logic [STAMP_W-1:0] diff;
    diff = STAMP_W'(b - a);
    return (a != b) && (diff[STAMP_W-1] == 1'b0);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback sources, register-file write port and hazard query bundle.
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [REG_SEL_W-1:0] alu_sel;
  logic [DATA_W-1:0]    alu_data;

  logic                 mem_valid;
  logic                 mem_ready;
  logic [REG_SEL_W-1:0] mem_sel;
  logic [DATA_W-1:0]    mem_data;

  logic                 rf_write;
  logic [REG_SEL_W-1:0] rf_writeregsel;
  logic [DATA_W-1:0]    rf_writedata;

  logic [REG_SEL_W-1:0] chk_sel;
  logic                 chk_pending;

  modport master (
    output alu_valid, alu_sel, alu_data,
    output mem_valid, mem_sel, mem_data,
    output chk_sel,
    input  alu_ready, mem_ready,
    input  rf_write, rf_writeregsel, rf_writedata,
    input  chk_pending
  );

  modport slave (
    input  alu_valid, alu_sel, alu_data,
    input  mem_valid, mem_sel, mem_data,
    input  chk_sel,
    output alu_ready, mem_ready,
    output rf_write, rf_writeregsel, rf_writedata,
    output chk_pending
  );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Small shifting FIFO of writeback entries; slot 0 is always the head.
module wb_fifo
  import rf_wb_arbiter_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push,
  input  wb_entry_t                            push_entry,
  input  logic                                 pop,
  output wb_entry_t                            head,
  output logic [CNT_W-1:0]                     count,
  output logic [FIFO_DEPTH-1:0][REG_SEL_W-1:0] entry_sel,
  output logic [FIFO_DEPTH-1:0]                entry_valid,
  output logic [STAMP_W-1:0]                   tail_stamp
);

  localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  wb_entry_t        slots [FIFO_DEPTH];
  logic             push_ok;
  logic             pop_ok;
  logic [IDX_W-1:0] wr_idx;

  assign push_ok = push && (count < CNT_W'(FIFO_DEPTH));
  assign pop_ok  = pop && (count != '0);
  // After a pop the first free slot moves down by one.
  assign wr_idx  = IDX_W'(pop_ok ? count - CNT_W'(1) : count);

  // Storage and occupancy; pop shifts toward the head, push fills the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) slots[i] <= '0;
    end else begin
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (pop_ok) begin
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) slots[i] <= slots[i+1];
      end
      if (push_ok) slots[wr_idx] <= push_entry;
    end
  end

  // Per-slot visibility for hazard lookups.
  always_comb begin
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      entry_sel[i]   = slots[i].sel;
      entry_valid[i] = (count > CNT_W'(i));
    end
  end

  assign head       = slots[0];
  assign tail_stamp = slots[FIFO_DEPTH-1].stamp;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto a single registered register-file
// write port, keeping same-register writes in arrival order.
// Optional: RF_WB_R0_DROP_EN discards writebacks targeting register 0.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  rf_wb_arbiter_if.slave bus
);

  wb_entry_t                            alu_head, mem_head;
  wb_entry_t                            alu_in, mem_in;
  logic [CNT_W-1:0]                     alu_count, mem_count;
  logic [FIFO_DEPTH-1:0][REG_SEL_W-1:0] alu_sels, mem_sels;
  logic [FIFO_DEPTH-1:0]                alu_vld, mem_vld;
  logic [STAMP_W-1:0]                   alu_tail_stamp, mem_tail_stamp;

  logic               alu_acc, mem_acc;
  logic               alu_push, mem_push;
  logic               grant_alu, grant_mem;
  logic               alu_blocked, mem_blocked;
  logic               pending;
  logic [STAMP_W-1:0] stamp_q;
  arb_state_t         state;

  logic                 rf_write_q;
  logic [REG_SEL_W-1:0] rf_sel_q;
  logic [DATA_W-1:0]    rf_data_q;

  // Ready depends only on registered occupancy and is held low in reset.
  assign bus.alu_ready = rst_n & (alu_count < CNT_W'(FIFO_DEPTH));
  assign bus.mem_ready = rst_n & (mem_count < CNT_W'(FIFO_DEPTH));

  assign alu_acc = bus.alu_valid & bus.alu_ready;
  assign mem_acc = bus.mem_valid & bus.mem_ready;

`ifdef RF_WB_R0_DROP_EN
  assign alu_push = alu_acc & (bus.alu_sel != '0);
  assign mem_push = mem_acc & (bus.mem_sel != '0);
`else
  assign alu_push = alu_acc;
  assign mem_push = mem_acc;
`endif

  // On a simultaneous accept the load is treated as the older beat.
  assign mem_in = '{sel: bus.mem_sel, data: bus.mem_data, stamp: stamp_q};
  assign alu_in = '{sel: bus.alu_sel, data: bus.alu_data,
                    stamp: mem_push ? STAMP_W'(stamp_q + STAMP_W'(1)) : stamp_q};

  // Arrival stamp counter, advanced once per stamped beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stamp_q <= '0;
    else        stamp_q <= stamp_q + STAMP_W'(alu_push) + STAMP_W'(mem_push);
  end

  wb_fifo u_alu_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (alu_push),
    .push_entry  (alu_in),
    .pop         (grant_alu),
    .head        (alu_head),
    .count       (alu_count),
    .entry_sel   (alu_sels),
    .entry_valid (alu_vld),
    .tail_stamp  (alu_tail_stamp)
  );

  wb_fifo u_mem_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (mem_push),
    .push_entry  (mem_in),
    .pop         (grant_mem),
    .head        (mem_head),
    .count       (mem_count),
    .entry_sel   (mem_sels),
    .entry_valid (mem_vld),
    .tail_stamp  (mem_tail_stamp)
  );

  // Grant selection: sole requester, then age for same register, else round-robin.
  // A head is held back when an older write to its register sits behind the other head.
  always_comb begin
    grant_alu   = 1'b0;
    grant_mem   = 1'b0;
    alu_blocked = mem_vld[FIFO_DEPTH-1] && (mem_sels[FIFO_DEPTH-1] == alu_head.sel) &&
                  is_older(mem_tail_stamp, alu_head.stamp);
    mem_blocked = alu_vld[FIFO_DEPTH-1] && (alu_sels[FIFO_DEPTH-1] == mem_head.sel) &&
                  is_older(alu_tail_stamp, mem_head.stamp);
    if (alu_vld[0] && !mem_vld[0]) begin
      grant_alu = 1'b1;
    end else if (!alu_vld[0] && mem_vld[0]) begin
      grant_mem = 1'b1;
    end else if (alu_vld[0] && mem_vld[0]) begin
      if (alu_head.sel == mem_head.sel) begin
        if (is_older(alu_head.stamp, mem_head.stamp)) grant_alu = 1'b1;
        else                                          grant_mem = 1'b1;
      end else if (alu_blocked) begin
        grant_mem = 1'b1;
      end else if (mem_blocked) begin
        grant_alu = 1'b1;
      end else if (state == LAST_MEM) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end
  end

  // Round-robin state follows every grant, whatever decided it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         state <= LAST_MEM;
    else if (grant_alu) state <= LAST_ALU;
    else if (grant_mem) state <= LAST_MEM;
  end

  // Register-file write port, loaded from the granted head; sel/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_q <= 1'b0;
      rf_sel_q   <= '0;
      rf_data_q  <= '0;
    end else if (grant_alu) begin
      rf_write_q <= 1'b1;
      rf_sel_q   <= alu_head.sel;
      rf_data_q  <= alu_head.data;
    end else if (grant_mem) begin
      rf_write_q <= 1'b1;
      rf_sel_q   <= mem_head.sel;
      rf_data_q  <= mem_head.data;
    end else begin
      rf_write_q <= 1'b0;
    end
  end

  assign bus.rf_write       = rf_write_q;
  assign bus.rf_writeregsel = rf_sel_q;
  assign bus.rf_writedata   = rf_data_q;

  // Hazard query over every queued entry plus the write in flight.
  always_comb begin
    pending = rf_write_q && (rf_sel_q == bus.chk_sel);
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (alu_vld[i] && (alu_sels[i] == bus.chk_sel)) pending = 1'b1;
      if (mem_vld[i] && (mem_sels[i] == bus.chk_sel)) pending = 1'b1;
    end
`ifdef RF_WB_R0_DROP_EN
    if (bus.chk_sel == '0) pending = 1'b0;
`endif
  end

  assign bus.chk_pending = pending;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: per-register ordered scoreboard with
// directed latency, round-robin, ordering, reset and r0 scenarios plus random traffic.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int NREG = 1 << REG_SEL_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rf_wb_arbiter_if wb ();

  rf_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wb)
  );

  int              n_checks = 0;
  int              n_pass   = 0;
  logic [31:0]     exp_q [NREG][$];
  logic [31:0]     last_val [NREG];
  int              writes_to [NREG];
  bit              mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Every accepted beat that should produce a write, queued per destination register.
  function automatic void model_push(input logic [4:0] s, input logic [31:0] d);
`ifdef RF_WB_R0_DROP_EN
    if (s == 5'd0) return;
`endif
    exp_q[s].push_back(d);
  endfunction

  function automatic int model_outstanding();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += exp_q[r].size();
    return n;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) exp_q[r].delete();
  endfunction

  // Monitor: every write must be the oldest outstanding beat for its register.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        pend_exp;
      logic [31:0] want;
      if (wb.rf_write) begin
        if (exp_q[wb.rf_writeregsel].size() == 0) begin
          check("queued_beat_for_written_reg", 32'(0), 32'(1));
        end else begin
          want = exp_q[wb.rf_writeregsel].pop_front();
          check("write_data", wb.rf_writedata, want);
        end
        last_val[wb.rf_writeregsel] = wb.rf_writedata;
        writes_to[wb.rf_writeregsel]++;
      end
      pend_exp = (exp_q[wb.chk_sel].size() != 0) ||
                 (wb.rf_write && (wb.rf_writeregsel == wb.chk_sel));
`ifdef RF_WB_R0_DROP_EN
      if (wb.chk_sel == 5'd0) pend_exp = 1'b0;
`endif
      check("chk_pending", 32'(wb.chk_pending), 32'(pend_exp));
    end
  end

  // One cycle of stimulus; reports which beats the next posedge accepts.
  task automatic cycle(input logic av, input logic [4:0] as, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ms, input logic [31:0] md,
                       input logic [4:0] cs, output logic a_acc, output logic m_acc);
    @(negedge clk);
    #1;
    wb.alu_valid = av; wb.alu_sel = as; wb.alu_data = ad;
    wb.mem_valid = mv; wb.mem_sel = ms; wb.mem_data = md;
    wb.chk_sel   = cs;
    m_acc = mv && wb.mem_ready;
    a_acc = av && wb.alu_ready;
    if (m_acc) model_push(ms, md);
    if (a_acc) model_push(as, ad);
  endtask

  task automatic idle(input logic [4:0] cs);
    logic a, m;
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, cs, a, m);
  endtask

  task automatic drain();
    int k = 0;
    while (model_outstanding() != 0 && k < 50) begin
      idle(5'($urandom_range(0, 7)));
      k++;
    end
    check("drain_complete", 32'(model_outstanding()), 32'(0));
  endtask

  task automatic do_reset(input logic [4:0] cs);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mon_en = 1'b0;
    wb.chk_sel = cs;
    #1;
    check("rst_rf_write", 32'(wb.rf_write), 32'(0));
    check("rst_alu_ready", 32'(wb.alu_ready), 32'(0));
    check("rst_mem_ready", 32'(wb.mem_ready), 32'(0));
    check("rst_chk_pending", 32'(wb.chk_pending), 32'(0));
    wb.alu_valid = 1'b0;
    wb.mem_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_alu_ready", 32'(wb.alu_ready), 32'(1));
    check("post_rst_mem_ready", 32'(wb.mem_ready), 32'(1));
    mon_en = 1'b1;
  endtask

  // Both sources valid every cycle with disjoint register ranges; holds a beat until accepted.
  task automatic stream(input int n, input bit check_rr);
    int   ai = 0;
    int   mi = 0;
    logic aa, ma;
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, 5'(1 + ai % 8), 32'h100 + 32'(ai),
            1'b1, 5'(16 + mi % 8), 32'h200 + 32'(mi),
            5'(1 + ai % 8), aa, ma);
      if (aa) ai++;
      if (ma) mi++;
      if (check_rr) begin
        #1;
        if (k == 1) begin
          check("rr_alu_ready_k1", 32'(wb.alu_ready), 32'(1));
          check("rr_mem_ready_k1", 32'(wb.mem_ready), 32'(1));
        end
        if (k == 2) check("rr_mem_ready_full", 32'(wb.mem_ready), 32'(0));
        if (k >= 2) begin
          check("rr_rf_write", 32'(wb.rf_write), 32'(1));
          check("rr_src_is_mem", 32'(wb.rf_writeregsel >= 5'd16), 32'(k % 2 == 1));
        end
      end
    end
  endtask

  initial begin
    logic        aa, ma;
    logic        av, mv;
    logic [4:0]  as, ms;
    logic [31:0] ad, md;
    int          w5, w7;

    wb.alu_valid = 1'b0; wb.alu_sel = '0; wb.alu_data = '0;
    wb.mem_valid = 1'b0; wb.mem_sel = '0; wb.mem_data = '0;
    wb.chk_sel   = '0;
    for (int r = 0; r < NREG; r++) begin
      last_val[r]  = '0;
      writes_to[r] = 0;
    end

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("init_rf_write", 32'(wb.rf_write), 32'(0));
    check("init_rf_writeregsel", 32'(wb.rf_writeregsel), 32'(0));
    check("init_rf_writedata", wb.rf_writedata, 32'(0));
    check("init_alu_ready", 32'(wb.alu_ready), 32'(0));
    check("init_mem_ready", 32'(wb.mem_ready), 32'(0));
    check("init_chk_pending", 32'(wb.chk_pending), 32'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("init_alu_ready_rel", 32'(wb.alu_ready), 32'(1));
    check("init_mem_ready_rel", 32'(wb.mem_ready), 32'(1));
    mon_en = 1'b1;

    // Single ALU beat: two-cycle latency and pending window
    cycle(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd3, aa, ma);
    check("lat_accept", 32'(aa), 32'(1));
    idle(5'd3); #1;
    check("lat_no_write_yet", 32'(wb.rf_write), 32'(0));
    check("lat_pending_queued", 32'(wb.chk_pending), 32'(1));
    idle(5'd3); #1;
    check("lat_rf_write", 32'(wb.rf_write), 32'(1));
    check("lat_rf_sel", 32'(wb.rf_writeregsel), 32'(3));
    check("lat_rf_data", wb.rf_writedata, 32'h11);
    check("lat_pending_inflight", 32'(wb.chk_pending), 32'(1));
    idle(5'd3); #1;
    check("lat_write_done", 32'(wb.rf_write), 32'(0));
    check("lat_pending_clear", 32'(wb.chk_pending), 32'(0));

    // Register 0 beat
    cycle(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0, aa, ma);
    check("r0_accept", 32'(aa), 32'(1));
    idle(5'd0); #1;
`ifdef RF_WB_R0_DROP_EN
    check("r0_pending_drop", 32'(wb.chk_pending), 32'(0));
    idle(5'd0); #1;
    check("r0_no_write", 32'(wb.rf_write), 32'(0));
`else
    check("r0_pending", 32'(wb.chk_pending), 32'(1));
    idle(5'd0); #1;
    check("r0_rf_write", 32'(wb.rf_write), 32'(1));
    check("r0_rf_sel", 32'(wb.rf_writeregsel), 32'(0));
    check("r0_rf_data", wb.rf_writedata, 32'h55);
`endif
    drain();

    // Round-robin from reset: ALU first, then alternating every cycle
    do_reset(5'd1);
    stream(12, 1'b1);
    idle(5'd0);
    drain();

    // Same register, MEM then ALU on consecutive cycles
    w5 = writes_to[5];
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA, 5'd5, aa, ma);
    check("ord_mem_accept", 32'(ma), 32'(1));
    cycle(1'b1, 5'd5, 32'hB, 1'b0, 5'd0, 32'd0, 5'd5, aa, ma);
    check("ord_alu_accept", 32'(aa), 32'(1));
    drain();
    check("ord_r5_writes", 32'(writes_to[5] - w5), 32'(2));
    check("ord_r5_final", last_val[5], 32'hB);

    // Simultaneous accept to the same register: MEM is older
    w7 = writes_to[7];
    cycle(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, aa, ma);
    check("sim_both_accept", 32'(aa && ma), 32'(1));
    idle(5'd7); #1;
    check("sim_no_write_yet", 32'(wb.rf_write), 32'(0));
    idle(5'd7); #1;
    check("sim_first_write", 32'(wb.rf_write), 32'(1));
    check("sim_first_data", wb.rf_writedata, 32'h2);
    idle(5'd7); #1;
    check("sim_second_write", 32'(wb.rf_write), 32'(1));
    check("sim_second_data", wb.rf_writedata, 32'h1);
    drain();
    check("sim_r7_writes", 32'(writes_to[7] - w7), 32'(2));
    check("sim_r7_final", last_val[7], 32'h1);

    // Random traffic on a small register set to force collisions
    av = 1'b0; mv = 1'b0; aa = 1'b1; ma = 1'b1;
    as = '0; ms = '0; ad = '0; md = '0;
    for (int i = 0; i < 400; i++) begin
      if (!av || aa) begin
        av = ($urandom_range(0, 3) != 0);
        as = 5'($urandom_range(0, 7));
        ad = $urandom;
      end
      if (!mv || ma) begin
        mv = ($urandom_range(0, 3) != 0);
        ms = 5'($urandom_range(0, 7));
        md = $urandom;
      end
      cycle(av, as, ad, mv, ms, md, 5'($urandom_range(0, 7)), aa, ma);
    end
    idle(5'd0);
    drain();

    // Reset in the middle of a full stream discards everything
    stream(4, 1'b0);
    do_reset(5'd1);
    #1;
    check("midrst_rf_write", 32'(wb.rf_write), 32'(0));
    repeat (6) idle(5'd1);
    #1;
    check("midrst_alu_ready", 32'(wb.alu_ready), 32'(1));
    check("midrst_mem_ready", 32'(wb.mem_ready), 32'(1));
    check("midrst_no_write", 32'(wb.rf_write), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
